// File: rtl/ssd_driver_if.sv
// ssd_driver_if: bundle between the value source and the seven-segment back-end.
//
// Signals:
//   value      binary value to display (0..8191), driven by the source
//   Anode      digit enables, active-low, Anode[3] = thousands digit
//   LED_out    segments, active-low, bit6=a ... bit0=g
//   bcd        committed BCD digits {thousands, hundreds, tens, units}
//   conv_done  one-cycle strobe on the cycle bcd takes a new value
//   fsm_state  conversion FSM state (0=IDLE, 1=SHIFT, 2=COMMIT), for debug
//
// Handshake: there is no backpressure. value is a level that the back-end
// samples whenever it is idle; conv_done is a valid-only strobe (no ready),
// and bcd is stable from one conv_done to the next.
interface ssd_driver_if;
  logic [12:0] value;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;
  logic [15:0] bcd;
  logic        conv_done;
  logic [1:0]  fsm_state;

  modport master (
    output value,
    input  Anode,
    input  LED_out,
    input  bcd,
    input  conv_done,
    input  fsm_state
  );

  modport slave (
    input  value,
    output Anode,
    output LED_out,
    output bcd,
    output conv_done,
    output fsm_state
  );
endinterface

// File: rtl/ssd_driver.sv
// ssd_driver: 4-digit common-anode seven-segment display back-end.
//
// A sequential double-dabble engine converts the 13-bit unsigned value into
// four BCD digits (13 shift iterations, one per cycle), and a free-running
// prescaler time-multiplexes the committed digits onto Anode/LED_out.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-low reset
//   bus    ssd_driver_if.slave (value in; Anode, LED_out, bcd, conv_done,
//          fsm_state out)
//
// Parameters:
//   DIGIT_CYCLES  cycles each digit stays lit (2..2^20)
//   BLANK_LZ      1 = blank leading zeros of digits 3..1
module ssd_driver #(
  parameter int DIGIT_CYCLES = 100000,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  ssd_driver_if.slave  bus
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state;
  logic [12:0] shift_bin;
  logic [15:0] bcd_acc;
  logic [12:0] last_value;
  logic        force_conv;
  logic [3:0]  iter;
  logic [15:0] bcd_q;
  logic        conv_done_q;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    anode_q;
  logic [6:0]    led_q;

  // Add 3 to every nibble >= 5 so the following shift carries correctly
  // into the next decimal digit.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < 4; i++) begin
      if (a[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One double-dabble step on the whole {bcd, bin} register.
  logic [28:0] shifted;
  assign shifted = {dabble_adjust(bcd_acc), shift_bin} << 1;

  // Conversion FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      shift_bin   <= '0;
      bcd_acc     <= '0;
      last_value  <= '0;
      force_conv  <= 1'b1;
      iter        <= '0;
      bcd_q       <= '0;
      conv_done_q <= 1'b0;
    end else begin
      conv_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.value != last_value || force_conv) begin
            shift_bin  <= bus.value;
            last_value <= bus.value;
            bcd_acc    <= '0;
            force_conv <= 1'b0;
            iter       <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_acc   <= shifted[28:13];
          shift_bin <= shifted[12:0];
          iter      <= iter + 4'd1;
          if (iter == 4'd12) state <= COMMIT;
        end
        COMMIT: begin
          bcd_q       <= bcd_acc;
          conv_done_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Leading-zero detection over the committed digits: lz[k] means digits
  // k..3 are all zero. Digit 0 is never blanked.
  logic [3:0] lz;
  logic [3:0] cur_digit;
  logic       blank;

  always_comb begin
    lz[3]     = (bcd_q[15:12] == 4'd0);
    lz[2]     = lz[3] && (bcd_q[11:8] == 4'd0);
    lz[1]     = lz[2] && (bcd_q[7:4] == 4'd0);
    lz[0]     = 1'b0;
    cur_digit = bcd_q[idx*4 +: 4];
    blank     = BLANK_LZ && lz[idx];
  end

  // Free-running scan plus registered display outputs (one cycle behind
  // idx/bcd_q).
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= '0;
      anode_q  <= 4'b1111;
      led_q    <= 7'b1111111;
    end else begin
      if (scan_cnt == CNT_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      anode_q <= ~(4'b0001 << idx);
      led_q   <= blank ? 7'b1111111 : seg_encode(cur_digit);
    end
  end

  assign bus.Anode     = anode_q;
  assign bus.LED_out   = led_q;
  assign bus.bcd       = bcd_q;
  assign bus.conv_done = conv_done_q;
  assign bus.fsm_state = state;

endmodule

// File: doc/ssd_driver.md
Name: ssd_driver

Overview:
- Display back-end fed by the processor's 13-bit debug selection (ssdOut). Drives the board's 4-digit, common-anode seven-segment display.
- Converts the unsigned binary value to 4 BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto Anode/LED_out using a refresh prescaler on the single system clock.

Parameters:
- DIGIT_CYCLES, 100000: clk cycles each digit stays lit before the scan advances. Legal range is 2..2^20. Benches use 4.
- BLANK_LZ, 1: when 1, leading zeros of digits 3..1 are blanked. Digit 0 is never blanked.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- value  in  13  unsigned binary value to display (0..8191).
- Anode  out  4  digit enables, active-low; Anode[3] is the thousands digit.
- LED_out  out  7  segments, active-low; bit6=a ... bit0=g.
- bcd  out  16  committed BCD digits {thousands, hundreds, tens, units}.
- conv_done  out  1  one-cycle pulse on the cycle bcd takes a new value.

Behaviour:
- Reset (reset==0 at an edge) forces:
  - Anode=4'b1111, LED_out=7'b1111111, bcd=0, conv_done=0.
  - Scan counter=0, digit index=0, FSM=IDLE, last_value=0.
  - force_conv=1, so a conversion of the current value starts on the first non-reset cycle.
- Reset asserted mid-conversion aborts it. bcd does not update.
- Conversion FSM has three states: IDLE, SHIFT, COMMIT.
- IDLE:
  - Start when value!=last_value or force_conv==1.
  - On start: capture value into the shift register and into last_value, clear the BCD accumulator, clear force_conv, set iteration count to 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Add 3 to every BCD nibble >=5.
  - Then shift {bcd_acc, bin} left by 1.
  - After the 13th iteration, go to COMMIT.
- COMMIT: bcd<=bcd_acc, conv_done<=1 for exactly one cycle, go to IDLE.
- Latency: value sampled at edge E gives bcd/conv_done visible after edge E+14. Minimum spacing between conversions is 15 cycles.
- value changes during SHIFT/COMMIT are ignored. They are picked up in the next IDLE via the last_value compare. Only the latest value is converted; intermediate values may be skipped.
- Every value 0..8191 produces a valid BCD result. No overflow is possible.
- Scan:
  - Counter runs 0..DIGIT_CYCLES-1 and wraps to 0.
  - On wrap, the digit index advances 0->1->2->3->0.
  - The scan is free-running, independent of the FSM.
- Outputs are registered. Each cycle, Anode=~(4'b0001<<idx) and LED_out=segment encoding of bcd digit idx, both from the previous cycle's idx and bcd (1-cycle latency).
- Segment encoding, values 0-9:
  - 0 -> 0000001
  - 1 -> 1001111
  - 2 -> 0010010
  - 3 -> 0000110
  - 4 -> 1001100
  - 5 -> 0100100
  - 6 -> 0100000
  - 7 -> 0001111
  - 8 -> 0000000
  - 9 -> 0000100
- Any non-BCD nibble (unreachable) encodes 1111111.
- Blanking (BLANK_LZ=1): digit k is blanked (LED_out=1111111) if k>0 and all committed digits k..3 are zero. Anode is still driven normally for a blanked digit.
- bcd updates only at COMMIT, so a digit never shows a partially converted value.

Test Plan:
- Reset with reset=0 for 3 cycles, value=13'd1234 -> during reset Anode=1111, LED_out=1111111, bcd=0. After release, conv_done pulses exactly 14 edges after the first non-reset edge, and bcd=16'h1234.
- value=13'd8191 after an idle settle -> bcd=16'h8191 after 14 edges. With DIGIT_CYCLES=4, Anode cycles 1110,1101,1011,0111 every 4 cycles with LED_out = 1001111 (1), 0000100 (9), 1001111 (1), 0000000 (8).
- value=13'd7, BLANK_LZ=1 -> bcd=16'h0007. Digit 0 shows 0001111; digits 1..3 show 1111111 while their Anode bit is low. Value=0 -> digit0=0000001, others blank.
- value changes 100->200 on the 5th SHIFT cycle -> first conv_done gives bcd=16'h0100. A second conversion starts in the following IDLE, and its conv_done (15 edges after the first) gives bcd=16'h0200. No other conv_done pulses occur.
- reset=0 for one cycle during SHIFT of value 4321, previous bcd=16'h0055 -> bcd=0, no conv_done during the aborted run. A fresh conversion completes 14 edges after release with bcd=16'h4321.
- Constant value held for 1000 cycles -> exactly one conv_done after reset, then none. Scan counter wraps correctly at DIGIT_CYCLES-1.
